jt12_ch_wrdec: RTL and testbench
================================

// Module: jt12_ch_wrdec
// PURPOSE
//  CPU-side write decoder for per-channel registers (A0-A6, B0-B6). Sits directly
//  upstream of the channel register file. Converts address/data port writes into
//  single-cycle update strobes, a channel index and a held data byte. Owns the
//  shared F-number-high/block latch (A4-A6), which is applied on the following
//  F-number-low write.
// PARAMETERS
//  NUM_CH    6   channels: 6 = two parts (A1 selects part), 3 = part bit ignored
//  BUSY_CYC  32  cen ticks busy stays high after an applied data write (macro on)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  cen         in   1  chip clock enable
//  write       in   1  CPU write strobe, one clk wide
//  addr        in   2  [0]: 0 = address port, 1 = data port; [1]: part
//  din         in   8  CPU data
//  dout        out  8  held data byte for the register file
//  up_ch       out  3  target channel 0..NUM_CH-1
//  latch_fnum  out  6  {block[2:0], fnum[10:8]} latch
//  up_fnumlo   out  1  strobe: A0-A2 write
//  up_alg      out  1  strobe: B0-B2 write
//  up_pms      out  1  strobe: B4-B6 write
//  busy        out  1  chip busy flag
//  overrun     out  1  one-clk pulse: data write dropped
// BEHAVIOUR
//  - Reset: all outputs 0. Address latch = 0x00, part = 0, state IDLE.
//  - Address write (addr[0]=0): sets sel_reg <= din and sel_part <= addr[1]
//    (forced 0 when NUM_CH==3). Accepted in every state. Never stalls.
//  - Data write (addr[0]=1) in IDLE: capture {sel_reg, sel_part, din}, go to PEND.
//    A data write in PEND or BUSY is dropped and pulses overrun for 1 clk.
//  - PEND: on first clk with cen=1, decode the captured register and emit strobes.
//    Then go to BUSY (macro on) or IDLE (macro off).
//  - Decode, with r = captured register and lo = r[1:0]:
//    - lo==3: no effect, no strobe. Same for any r outside A0-B6.
//    - up_ch = sel_part ? lo+3 : lo.
//    - A0-A2: up_fnumlo=1, dout=din. latch_fnum is unchanged.
//    - A4-A6: latch_fnum <= din[5:0] at decode cycle; shared by all channels; no strobe.
//    - B0-B2: up_alg=1. B4-B6: up_pms=1. Other rows (A8-AE, B8+) ignored.
//  - Strobes are exactly 1 clk wide. dout/up_ch are valid that cycle and hold
//    until the next decode.
//  - Latency: write at clk n -> strobe at first cen-high clk > n.
//  - Write coincident with decode clk in PEND: dropped (overrun).
//  - Reset mid-PEND/BUSY: pending write discarded, no strobe, busy=0.
// CONFIGURATION
//  JT12_WRDEC_BUSY_EN defined:
//    - busy rises on the decode clk and stays high for BUSY_CYC cen ticks.
//    - Down-counter is clog2(BUSY_CYC+1) bits; state returns to IDLE when the count hits 0.
//    - busy falls on that clk; a write on that same clk is accepted.
//  JT12_WRDEC_BUSY_EN undefined:
//    - busy tied 0 and the BUSY state is absent.
//    - Only writes arriving while PEND produce overrun.
// TESTING
//  1. Write addr 0xA4 then data 0x2B, then addr 0xA0 then data 0x55
//     -> latch_fnum=0x2B; one up_fnumlo pulse, up_ch=0, dout=0x55.
//  2. addr[1]=1, reg 0xB2, data 0x3A (NUM_CH=6)
//     -> up_alg pulse, up_ch=5, dout=0x3A. With NUM_CH=3 -> up_ch=2.
//  3. Reg 0xA3 or 0xB8, any data -> no strobe, latch_fnum unchanged, state returns to IDLE.
//  4. cen every 4 clk, data write on clk 1
//     -> strobe on first cen-high clk; a second data write before it -> overrun pulse,
//        and only the first write is decoded.
//  5. Macro on, BUSY_CYC=32: write B4=0xC7
//     -> up_pms pulse, busy high exactly 32 cen ticks; a write mid-busy is dropped.
//  6. Assert rst while PEND -> no strobe ever issued; all outputs 0; address latch 0x00.

Source files
------------

// File: rtl/jt12_ch_wrdec.sv
// jt12_ch_wrdec: CPU write decoder for the per-channel registers A0-A6 and B0-B6.
// Converts address/data port writes into single-clk update strobes, a channel
// index and a held data byte, and owns the shared F-number-high/block latch.
// Optional feature: define JT12_WRDEC_BUSY_EN to enable the busy flag and BUSY state.
module jt12_ch_wrdec #(
    parameter int NUM_CH   = 6,
    parameter int BUSY_CYC = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       write,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [2:0] up_ch,
    output logic [5:0] latch_fnum,
    output logic       up_fnumlo,
    output logic       up_alg,
    output logic       up_pms,
    output logic       busy,
    output logic       overrun
);

`ifdef JT12_WRDEC_BUSY_EN
    localparam int CNT_W = $clog2(BUSY_CYC + 1);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_BUSY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_PEND} state_t;
`endif

    state_t     state;
    logic [7:0] sel_reg;
    logic       sel_part;
    logic [7:0] cap_reg;
    logic [7:0] cap_din;
    logic       cap_part;

    logic       wr_addr, wr_data, part_in;
    logic [1:0] lo;
    logic       row_a, row_b, grp0, grp1, lo_ok;
    logic       dec_fnumlo, dec_latch, dec_alg, dec_pms, dec_any;
    logic [2:0] dec_ch;

    // Port qualification and decode of the captured register
    always_comb begin
        wr_addr    = write & ~addr[0];
        wr_data    = write &  addr[0];
        part_in    = (NUM_CH > 3) ? addr[1] : 1'b0;
        lo         = cap_reg[1:0];
        lo_ok      = (lo != 2'd3);
        row_a      = (cap_reg[7:4] == 4'hA);
        row_b      = (cap_reg[7:4] == 4'hB);
        grp0       = (cap_reg[3:2] == 2'd0);
        grp1       = (cap_reg[3:2] == 2'd1);
        dec_fnumlo = row_a & grp0 & lo_ok;
        dec_latch  = row_a & grp1 & lo_ok;
        dec_alg    = row_b & grp0 & lo_ok;
        dec_pms    = row_b & grp1 & lo_ok;
        dec_any    = dec_fnumlo | dec_latch | dec_alg | dec_pms;
        dec_ch     = cap_part ? ({1'b0, lo} + 3'd3) : {1'b0, lo};
    end

    // Address latch: accepted in every state, never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg  <= '0;
            sel_part <= 1'b0;
        end else if (wr_addr) begin
            sel_reg  <= din;
            sel_part <= part_in;
        end
    end

`ifdef JT12_WRDEC_BUSY_EN
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Write FSM with registered strobes, data, channel, latch and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cap_reg    <= '0;
            cap_din    <= '0;
            cap_part   <= 1'b0;
            dout       <= '0;
            up_ch      <= '0;
            latch_fnum <= '0;
            up_fnumlo  <= 1'b0;
            up_alg     <= 1'b0;
            up_pms     <= 1'b0;
            overrun    <= 1'b0;
`ifdef JT12_WRDEC_BUSY_EN
            busy       <= 1'b0;
            busy_cnt   <= '0;
`endif
        end else begin
            up_fnumlo <= 1'b0;
            up_alg    <= 1'b0;
            up_pms    <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_data) begin
                        cap_reg  <= sel_reg;
                        cap_part <= sel_part;
                        cap_din  <= din;
                        state    <= S_PEND;
                    end
                end
                S_PEND: begin
                    // A write on the decode clk itself is also dropped
                    if (wr_data)
                        overrun <= 1'b1;
                    if (cen) begin
                        if (dec_latch)
                            latch_fnum <= cap_din[5:0];
                        if (dec_fnumlo | dec_alg | dec_pms) begin
                            dout  <= cap_din;
                            up_ch <= dec_ch;
                        end
                        up_fnumlo <= dec_fnumlo;
                        up_alg    <= dec_alg;
                        up_pms    <= dec_pms;
`ifdef JT12_WRDEC_BUSY_EN
                        if (dec_any) begin
                            busy     <= 1'b1;
                            busy_cnt <= CNT_W'(BUSY_CYC);
                            state    <= S_BUSY;
                        end else begin
                            state    <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
`ifdef JT12_WRDEC_BUSY_EN
                S_BUSY: begin
                    // The clk on which the count reaches 0 also accepts a new write
                    if (cen && busy_cnt == CNT_W'(1)) begin
                        busy_cnt <= '0;
                        busy     <= 1'b0;
                        if (wr_data) begin
                            cap_reg  <= sel_reg;
                            cap_part <= sel_part;
                            cap_din  <= din;
                            state    <= S_PEND;
                        end else begin
                            state    <= S_IDLE;
                        end
                    end else begin
                        if (cen)
                            busy_cnt <= busy_cnt - CNT_W'(1);
                        if (wr_data)
                            overrun <= 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef JT12_WRDEC_BUSY_EN
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_ch_wrdec.sv
// Directed bench for jt12_ch_wrdec: a 6-channel and a 3-channel instance share stimulus.
module tb_jt12_ch_wrdec;

    logic       clk = 1'b0;
    logic       rst, cen, write;
    logic [1:0] addr;
    logic [7:0] din;

    logic [7:0] dout, dout_3;
    logic [2:0] up_ch, up_ch_3;
    logic [5:0] latch_fnum, latch_fnum_3;
    logic       up_fnumlo, up_alg, up_pms, busy, overrun;
    logic       up_fnumlo_3, up_alg_3, up_pms_3, busy_3, overrun_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt12_ch_wrdec #(.NUM_CH(6), .BUSY_CYC(32)) dut (
        .clk(clk), .rst(rst), .cen(cen), .write(write), .addr(addr), .din(din),
        .dout(dout), .up_ch(up_ch), .latch_fnum(latch_fnum),
        .up_fnumlo(up_fnumlo), .up_alg(up_alg), .up_pms(up_pms),
        .busy(busy), .overrun(overrun)
    );

    jt12_ch_wrdec #(.NUM_CH(3), .BUSY_CYC(32)) dut3 (
        .clk(clk), .rst(rst), .cen(cen), .write(write), .addr(addr), .din(din),
        .dout(dout_3), .up_ch(up_ch_3), .latch_fnum(latch_fnum_3),
        .up_fnumlo(up_fnumlo_3), .up_alg(up_alg_3), .up_pms(up_pms_3),
        .busy(busy_3), .overrun(overrun_3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write = 1'b1;
        addr  = a;
        din   = d;
        step();
        write = 1'b0;
    endtask

    // Wait (bounded) until busy is low, with cen running
    task automatic settle();
        cen = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) break;
            step();
        end
        chk("settle_busy", {7'd0, busy}, 8'h00);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; write = 1'b0; addr = 2'b00; din = 8'h00;
        step(); step();
        chk("rst_dout", dout, 8'h00);
        chk("rst_ch", {5'd0, up_ch}, 8'h00);
        chk("rst_latch", {2'd0, latch_fnum}, 8'h00);
        chk("rst_strb", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        chk("rst_busy_ovr", {6'd0, busy, overrun}, 8'h00);
        rst = 1'b0;
        step();

        // 1: F-number high latch then F-number low write
        wr(2'b00, 8'hA4);
        wr(2'b01, 8'h2B);
        step();
        chk("t1_latch", {2'd0, latch_fnum}, 8'h2B);
        chk("t1_nostrb", {7'd0, up_fnumlo}, 8'h00);
        settle();
        wr(2'b00, 8'hA0);
        wr(2'b01, 8'h55);
        chk("t1_pre", {7'd0, up_fnumlo}, 8'h00);
        step();
        chk("t1_fnumlo", {7'd0, up_fnumlo}, 8'h01);
        chk("t1_ch", {5'd0, up_ch}, 8'h00);
        chk("t1_dout", dout, 8'h55);
        chk("t1_latch_keep", {2'd0, latch_fnum}, 8'h2B);
        step();
        chk("t1_width", {7'd0, up_fnumlo}, 8'h00);
        chk("t1_dout_hold", dout, 8'h55);
        settle();

        // 2: part 1, B2
        wr(2'b10, 8'hB2);
        wr(2'b11, 8'h3A);
        step();
        chk("t2_alg", {7'd0, up_alg}, 8'h01);
        chk("t2_ch6", {5'd0, up_ch}, 8'h05);
        chk("t2_ch3", {5'd0, up_ch_3}, 8'h02);
        chk("t2_dout", dout, 8'h3A);
        chk("t2_other", {6'd0, up_fnumlo, up_pms}, 8'h00);
        settle();

        // 3: unused slots produce nothing
        wr(2'b00, 8'hA3);
        wr(2'b01, 8'h77);
        step();
        chk("t3_a3_strb", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        chk("t3_a3_latch", {2'd0, latch_fnum}, 8'h2B);
        chk("t3_a3_dout", dout, 8'h3A);
        wr(2'b00, 8'hB8);
        wr(2'b01, 8'h11);
        step();
        chk("t3_b8_strb", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        chk("t3_b8_ovr", {7'd0, overrun}, 8'h00);
        // 5: B4 (next write is accepted, proving IDLE was reached)
        wr(2'b00, 8'hB4);
        wr(2'b01, 8'hC7);
        step();
        chk("t5_pms", {7'd0, up_pms}, 8'h01);
        chk("t5_ch", {5'd0, up_ch}, 8'h00);
        chk("t5_dout", dout, 8'hC7);
`ifdef JT12_WRDEC_BUSY_EN
        chk("t5_busy_rise", {7'd0, busy}, 8'h01);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t5_busy_hold", {7'd0, busy}, 8'h01);
        end
        wr(2'b01, 8'h01);
        chk("t5_mid_ovr", {7'd0, overrun}, 8'h01);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t5_busy_hold2", {7'd0, busy}, 8'h01);
            chk("t5_no_strb", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        end
        step();
        chk("t5_busy_fall", {7'd0, busy}, 8'h00);
`else
        chk("t5_busy_off", {7'd0, busy}, 8'h00);
`endif
        settle();

        // 4: slow cen, second write before decode is dropped
        cen = 1'b0;
        wr(2'b00, 8'hA1);
        wr(2'b01, 8'h12);
        wr(2'b01, 8'h34);
        chk("t4_ovr", {7'd0, overrun}, 8'h01);
        chk("t4_wait", {7'd0, up_fnumlo}, 8'h00);
        step();
        chk("t4_ovr_width", {7'd0, overrun}, 8'h00);
        chk("t4_wait2", {7'd0, up_fnumlo}, 8'h00);
        cen = 1'b1;
        step();
        chk("t4_fnumlo", {7'd0, up_fnumlo}, 8'h01);
        chk("t4_ch", {5'd0, up_ch}, 8'h01);
        chk("t4_dout", dout, 8'h12);
        settle();
        // write coincident with the decode clk
        wr(2'b00, 8'hA2);
        wr(2'b01, 8'h66);
        wr(2'b01, 8'h77);
        chk("t4c_fnumlo", {7'd0, up_fnumlo}, 8'h01);
        chk("t4c_dout", dout, 8'h66);
        chk("t4c_ch", {5'd0, up_ch}, 8'h02);
        chk("t4c_ovr", {7'd0, overrun}, 8'h01);
        step();
        chk("t4c_end", {6'd0, up_fnumlo, overrun}, 8'h00);
        settle();

        // 6: reset while PEND
        cen = 1'b0;
        wr(2'b00, 8'hB0);
        wr(2'b01, 8'h99);
        rst = 1'b1;
        #1;
        chk("t6_dout", dout, 8'h00);
        chk("t6_latch", {2'd0, latch_fnum}, 8'h00);
        chk("t6_ch", {5'd0, up_ch}, 8'h00);
        chk("t6_busy", {7'd0, busy}, 8'h00);
        step();
        rst = 1'b0;
        cen = 1'b1;
        step();
        chk("t6_no_alg", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        step();
        chk("t6_no_alg2", {7'd0, up_alg}, 8'h00);
        // address latch cleared to 0x00: data write decodes as unused
        wr(2'b01, 8'h44);
        step();
        chk("t6_sel0", {5'd0, up_fnumlo, up_alg, up_pms}, 8'h00);
        chk("t6_sel0_dout", dout, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
